// File: rtl/wb_stage_pkg.sv
// Write-back stage shared types: FSM encoding and load lane masks.
// Imported by the WB interface, the load aligner and the stage top.
package wb_stage_pkg;

  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_HOLD = 2'd2
  } wb_state_e;

  localparam logic [3:0] LSV_B = 4'b0001;
  localparam logic [3:0] LSV_H = 4'b0011;
  localparam logic [3:0] LSV_W = 4'b1111;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of WB pipeline register, data-bus response, regfile,
// bypass and trace signals shared by the pipeline and wb_stage.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic             ext_stall;
  logic [WB_DW-1:0] wb_pc;
  logic [WB_DW-1:0] wb_inst;
  logic [WB_DW-1:0] wb_res;
  logic             wb_load;
  logic             wb_loadX;
  logic [3:0]       wb_lsV;
  logic [1:0]       wb_data_addr;
  logic             wb_al;
  logic             wb_regwen;
  logic [4:0]       wb_wreg;
  logic             wb_data_req;
  logic             wb_cp0ren;
  logic [WB_DW-1:0] wb_cp0rdata;
  logic [1:0]       wb_hiloren;
  logic [WB_DW-1:0] wb_hilordata;
  logic             data_data_ok;
  logic [WB_DW-1:0] data_rdata;

  logic             wb_stall_req;
  logic             rf_wen;
  logic [4:0]       rf_waddr;
  logic [WB_DW-1:0] rf_wdata;
  logic             fwd_valid;
  logic [4:0]       fwd_reg;
  logic [WB_DW-1:0] fwd_data;
  logic [WB_DW-1:0] debug_wb_pc;
  logic [3:0]       debug_wb_rf_wen;
  logic [4:0]       debug_wb_rf_wnum;
  logic [WB_DW-1:0] debug_wb_rf_wdata;

  modport master (
    output ext_stall, wb_pc, wb_inst, wb_res,
    output wb_load, wb_loadX, wb_lsV, wb_data_addr,
    output wb_al, wb_regwen, wb_wreg, wb_data_req,
    output wb_cp0ren, wb_cp0rdata,
    output wb_hiloren, wb_hilordata,
    output data_data_ok, data_rdata,
    input  wb_stall_req, rf_wen, rf_waddr, rf_wdata,
    input  fwd_valid, fwd_reg, fwd_data,
    input  debug_wb_pc, debug_wb_rf_wen,
    input  debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  ext_stall, wb_pc, wb_inst, wb_res,
    input  wb_load, wb_loadX, wb_lsV, wb_data_addr,
    input  wb_al, wb_regwen, wb_wreg, wb_data_req,
    input  wb_cp0ren, wb_cp0rdata,
    input  wb_hiloren, wb_hilordata,
    input  data_data_ok, data_rdata,
    output wb_stall_req, rf_wen, rf_waddr, rf_wdata,
    output fwd_valid, fwd_reg, fwd_data,
    output debug_wb_pc, debug_wb_rf_wen,
    output debug_wb_rf_wnum, debug_wb_rf_wdata
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Load data aligner: shifts the addressed lane down and
// zero- or sign-extends byte and half loads.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [WB_DW-1:0] i_src,
  input  logic [1:0]       i_data_addr,
  input  logic [3:0]       i_lsv,
  input  logic             i_loadx,
  output logic [WB_DW-1:0] o_data
);

  logic [WB_DW-1:0] w_sh;
  logic             w_ext_b;
  logic             w_ext_h;

  assign w_sh    = i_src >> {i_data_addr, 3'b000};
  assign w_ext_b = ~i_loadx & w_sh[7];
  assign w_ext_h = ~i_loadx & w_sh[15];

  always_comb begin
    o_data = i_src;
    case (i_lsv)
      LSV_B:   o_data = {{24{w_ext_b}}, w_sh[7:0]};
      LSV_H:   o_data = {{16{w_ext_h}}, w_sh[15:0]};
      default: o_data = i_src;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: waits for load data, aligns it, picks the
// regfile write value and commits one write per instruction.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input logic      clk,
  input logic      reset,
  wb_stage_if.slave bus
);

  wb_state_e r_state;
  wb_state_e w_next;
  logic [DW-1:0] r_ld_buf;

  logic          w_need;
  logic          w_hold;
  logic          w_ready;
  logic          w_commit;
  logic          w_capture;
  logic [DW-1:0] w_src;
  logic [DW-1:0] w_ld_data;
  logic [DW-1:0] w_wdata;

  assign w_need    = bus.wb_data_req & bus.wb_load;
  assign w_hold    = (r_state == WB_HOLD);
  assign w_ready   = ~w_need | bus.data_data_ok | w_hold;
  assign w_commit  = w_ready & ~bus.ext_stall;
  assign w_capture = ~w_hold & w_need
                   & bus.data_data_ok & bus.ext_stall;

  always_comb begin
    w_next = r_state;
    case (r_state)
      WB_IDLE: begin
        if (w_need & ~bus.data_data_ok)
          w_next = WB_WAIT;
        else if (w_capture)
          w_next = WB_HOLD;
      end
      WB_WAIT: begin
        if (bus.data_data_ok)
          w_next = bus.ext_stall ? WB_HOLD : WB_IDLE;
      end
      WB_HOLD: begin
        if (~bus.ext_stall)
          w_next = WB_IDLE;
      end
      default: w_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= WB_IDLE;
      r_ld_buf <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture)
        r_ld_buf <= bus.data_rdata;
    end
  end

  assign w_src = w_hold ? r_ld_buf : bus.data_rdata;

  load_align u_align (
    .i_src       (w_src),
    .i_data_addr (bus.wb_data_addr),
    .i_lsv       (bus.wb_lsV),
    .i_loadx     (bus.wb_loadX),
    .o_data      (w_ld_data)
  );

  // Load beats link, CP0 and HI/LO reads; ALU result is the fallback.
  always_comb begin
    w_wdata = bus.wb_res;
    if (bus.wb_load)
      w_wdata = w_ld_data;
    else if (bus.wb_al)
      w_wdata = bus.wb_pc + 32'd8;
    else if (bus.wb_cp0ren)
      w_wdata = bus.wb_cp0rdata;
    else if (|bus.wb_hiloren)
      w_wdata = bus.wb_hilordata;
  end

  assign bus.wb_stall_req      = w_need & ~w_ready;
  assign bus.rf_wen            = w_commit & bus.wb_regwen;
  assign bus.rf_waddr          = bus.wb_wreg;
  assign bus.rf_wdata          = w_wdata;
  assign bus.fwd_valid         = bus.wb_regwen & w_ready;
  assign bus.fwd_reg           = bus.wb_wreg;
  assign bus.fwd_data          = w_wdata;
  assign bus.debug_wb_pc       = bus.wb_pc;
  assign bus.debug_wb_rf_wen   = {4{bus.rf_wen}};
  assign bus.debug_wb_rf_wnum  = bus.wb_wreg;
  assign bus.debug_wb_rf_wdata = w_wdata;

  a_no_ok_in_hold: assert property (
    @(posedge clk) disable iff (reset)
    !(w_hold && bus.data_data_ok)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, multi-cycle
// corner sequences and a randomized run against a load model.
module tb_wb_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage #(.DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear();
    bus.ext_stall    = 0; bus.wb_pc = 0; bus.wb_inst = 0;
    bus.wb_res       = 0; bus.wb_load = 0; bus.wb_loadX = 0;
    bus.wb_lsV       = 0; bus.wb_data_addr = 0; bus.wb_al = 0;
    bus.wb_regwen    = 0; bus.wb_wreg = 0; bus.wb_data_req = 0;
    bus.wb_cp0ren    = 0; bus.wb_cp0rdata = 0;
    bus.wb_hiloren   = 0; bus.wb_hilordata = 0;
    bus.data_data_ok = 0; bus.data_rdata = 0;
  endtask

  task automatic load(logic [3:0] lsv, logic [1:0] a,
                      logic x, logic [4:0] rd);
    clear();
    bus.wb_inst = 32'h8C00_0000; bus.wb_pc = 32'hBFC0_0100;
    bus.wb_load = 1; bus.wb_data_req = 1; bus.wb_lsV = lsv;
    bus.wb_data_addr = a; bus.wb_loadX = x;
    bus.wb_regwen = 1; bus.wb_wreg = rd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       nm;
    logic        ld, ldx, al, wen, c0;
    logic [3:0]  lsv;
    logic [1:0]  addr, hl;
    logic [4:0]  rd;
    logic [31:0] pc, res, c0d, hld, rdata;
    logic [31:0] e_wd;
    logic        e_wen;
  } vec_t;

  vec_t v[$];

  // high-level model state for the randomized run
  bit          m_have;
  logic [31:0] m_buf;

  function automatic logic [31:0] ref_wdata(logic [31:0] src);
    logic [7:0]  b;
    logic [15:0] h;
    int          sh;
    sh = 8 * int'(bus.wb_data_addr);
    b  = 8'((src >> sh) & 32'hFF);
    h  = 16'((src >> sh) & 32'hFFFF);
    if (bus.wb_load) begin
      if (bus.wb_lsV == 4'b0001)
        return bus.wb_loadX ? {24'd0, b} : 32'($signed(b));
      if (bus.wb_lsV == 4'b0011)
        return bus.wb_loadX ? {16'd0, h} : 32'($signed(h));
      return src;
    end
    if (bus.wb_al)      return bus.wb_pc + 32'd8;
    if (bus.wb_cp0ren)  return bus.wb_cp0rdata;
    if (bus.wb_hiloren != 0) return bus.wb_hilordata;
    return bus.wb_res;
  endfunction

  task automatic rand_instr();
    int k;
    clear();
    k = $urandom_range(0, 5);
    bus.wb_pc        = $urandom & 32'hFFFF_FFFC;
    bus.wb_inst      = $urandom | 32'h1;
    bus.wb_res       = $urandom;
    bus.wb_cp0rdata  = $urandom;
    bus.wb_hilordata = $urandom;
    bus.wb_regwen    = 1'($urandom_range(0, 3) != 0);
    bus.wb_wreg      = 5'($urandom);
    bus.wb_loadX     = 1'($urandom);
    if (k <= 2) begin
      bus.wb_load     = 1;
      bus.wb_data_req = 1'($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0: begin
          bus.wb_lsV = 4'b0001;
          bus.wb_data_addr = 2'($urandom);
        end
        1: begin
          bus.wb_lsV = 4'b0011;
          bus.wb_data_addr = {1'($urandom), 1'b0};
        end
        default: bus.wb_lsV = 4'b1111;
      endcase
    end else if (k == 3) begin
      bus.wb_al = 1;
    end else if (k == 4) begin
      bus.wb_cp0ren  = 1'($urandom);
      bus.wb_hiloren = 2'($urandom);
    end
  endtask

  initial begin
    int pulses;
    bit need, ready, commit;
    logic [31:0] src;

    clear();
    reset = 1;
    #12;
    chk("rst_wen",   32'(bus.rf_wen), 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_stall", 32'(bus.wb_stall_req), 0);
    chk("rst_fwd",   32'(bus.fwd_valid), 0);
    chk("rst_dpc",   bus.debug_wb_pc, 0);
    chk("rst_dwen",  32'(bus.debug_wb_rf_wen), 0);
    reset = 0;

    // nm ld ldx al wen c0 lsv addr hl rd pc res c0d hld rdata e_wd e_wen
    v.push_back('{"alu", 0,0,0,1,0, 4'h0,0,0, 3, 32'h0, 32'h1234_5678,
                  0, 0, 0, 32'h1234_5678, 1});
    v.push_back('{"jal", 0,0,1,1,0, 4'h0,0,0, 31, 32'hBFC0_0010,
                  32'h99, 0, 0, 0, 32'hBFC0_0018, 1});
    v.push_back('{"mfc0", 0,0,0,1,1, 4'h0,0,0, 4, 0, 32'h5,
                  32'h1, 0, 0, 32'h1, 1});
    v.push_back('{"mfhi", 0,0,0,1,0, 4'h0,0,2'b10, 5, 0, 32'h7,
                  0, 32'hCAFE_BABE, 0, 32'hCAFE_BABE, 1});
    v.push_back('{"c0_hl", 0,0,0,1,1, 4'h0,0,2'b01, 6, 0, 32'h7,
                  32'h0000_00C0, 32'hCAFE_BABE, 0, 32'h0000_00C0, 1});
    v.push_back('{"lw", 1,0,0,1,0, 4'hF,0,0, 8, 0, 32'h11,
                  0, 0, 32'h8000_1234, 32'h8000_1234, 1});
    v.push_back('{"lb3", 1,0,0,1,0, 4'h1,3,0, 9, 0, 0,
                  0, 0, 32'h8011_2233, 32'hFFFF_FF80, 1});
    v.push_back('{"lbu1", 1,1,0,1,0, 4'h1,1,0, 10, 0, 0,
                  0, 0, 32'h0000_9A00, 32'h0000_009A, 1});
    v.push_back('{"lb0p", 1,0,0,1,0, 4'h1,0,0, 11, 0, 0,
                  0, 0, 32'hFFFF_FF7F, 32'h0000_007F, 1});
    v.push_back('{"lh2", 1,0,0,1,0, 4'h3,2,0, 12, 0, 0,
                  0, 0, 32'h8001_0000, 32'hFFFF_8001, 1});
    v.push_back('{"lhu0", 1,1,0,1,0, 4'h3,0,0, 13, 0, 0,
                  0, 0, 32'h1234_F00D, 32'h0000_F00D, 1});
    v.push_back('{"ld_al", 1,0,1,1,0, 4'hF,0,0, 14, 32'h100, 0,
                  0, 0, 32'hDEAD_0001, 32'hDEAD_0001, 1});
    v.push_back('{"jalwrap", 0,0,1,1,0, 4'h0,0,0, 31, 32'hFFFF_FFFC,
                  0, 0, 0, 0, 32'h0000_0004, 1});
    v.push_back('{"bubble", 0,0,0,0,0, 4'h0,0,0, 0, 0, 0,
                  0, 0, 0, 32'h0, 0});
    v.push_back('{"nowen", 0,0,0,0,0, 4'h0,0,0, 7, 0, 32'h55,
                  0, 0, 0, 32'h55, 0});

    foreach (v[i]) begin
      tick();
      clear();
      bus.wb_load = v[i].ld; bus.wb_data_req = v[i].ld;
      bus.data_data_ok = v[i].ld; bus.wb_loadX = v[i].ldx;
      bus.wb_al = v[i].al; bus.wb_regwen = v[i].wen;
      bus.wb_cp0ren = v[i].c0; bus.wb_lsV = v[i].lsv;
      bus.wb_data_addr = v[i].addr; bus.wb_hiloren = v[i].hl;
      bus.wb_wreg = v[i].rd; bus.wb_pc = v[i].pc;
      bus.wb_res = v[i].res; bus.wb_cp0rdata = v[i].c0d;
      bus.wb_hilordata = v[i].hld; bus.data_rdata = v[i].rdata;
      #3;
      chk({v[i].nm, "_wd"},  bus.rf_wdata, v[i].e_wd);
      chk({v[i].nm, "_wen"}, 32'(bus.rf_wen), 32'(v[i].e_wen));
      chk({v[i].nm, "_dwen"}, 32'(bus.debug_wb_rf_wen),
          v[i].e_wen ? 32'hF : 32'h0);
      chk({v[i].nm, "_stl"}, 32'(bus.wb_stall_req), 0);
      chk({v[i].nm, "_fwd"}, 32'(bus.fwd_valid), 32'(v[i].wen));
    end

    // LB addr 3 with data three cycles late
    tick();
    load(4'h1, 2'd3, 1'b0, 5'd9);
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("lbw_stall", 32'(bus.wb_stall_req), 1);
      chk("lbw_wen",   32'(bus.rf_wen), 0);
      chk("lbw_fwd",   32'(bus.fwd_valid), 0);
      tick();
    end
    bus.data_data_ok = 1; bus.data_rdata = 32'h80AB_CDEF;
    #3;
    chk("lbw_stall_end", 32'(bus.wb_stall_req), 0);
    chk("lbw_wen_end",   32'(bus.rf_wen), 1);
    chk("lbw_wdata",     bus.rf_wdata, 32'hFFFF_FF80);

    // LHU addr 2, data arrives under ext_stall, held two cycles
    tick();
    load(4'h3, 2'd2, 1'b1, 5'd17);
    bus.ext_stall = 1; bus.data_data_ok = 1;
    bus.data_rdata = 32'hBEEF_0000;
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      #3;
      chk("hold_stall", 32'(bus.wb_stall_req), 0);
      pulses += int'(bus.rf_wen);
      tick();
      bus.data_data_ok = 0; bus.data_rdata = 32'h1234_5678;
    end
    chk("hold_fwd", bus.fwd_data, 32'h0000_BEEF);
    bus.ext_stall = 0;
    #3;
    chk("hold_wdata", bus.rf_wdata, 32'h0000_BEEF);
    pulses += int'(bus.rf_wen);
    tick();
    clear();
    #3;
    pulses += int'(bus.rf_wen);
    chk("hold_pulses", 32'(pulses), 1);

    // ALU op under a 5-cycle ext_stall, then a bubble
    tick();
    clear();
    bus.wb_regwen = 1; bus.wb_wreg = 5'd2; bus.wb_res = 32'h77;
    bus.ext_stall = 1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.ext_stall = 0;
      #3;
      pulses += int'(bus.rf_wen);
      tick();
    end
    clear();
    for (int c = 0; c < 3; c++) begin
      #3;
      pulses += int'(bus.rf_wen);
      tick();
    end
    chk("alu_pulses", 32'(pulses), 1);

    // reset in WAIT and in HOLD, then a clean LW
    load(4'hF, 2'd0, 1'b0, 5'd20);
    tick();
    #1 reset = 1;
    #1;
    chk("rstw_state", 32'(dut.r_state), 0);
    chk("rstw_wen",   32'(bus.rf_wen), 0);
    @(negedge clk); reset = 0;
    tick();
    bus.ext_stall = 1; bus.data_data_ok = 1;
    bus.data_rdata = 32'hA5A5_5A5A;
    tick();
    bus.data_data_ok = 0;
    #1;
    chk("rsth_pre_stall", 32'(bus.wb_stall_req), 0);
    reset = 1;
    #1;
    chk("rsth_stall", 32'(bus.wb_stall_req), 1);
    chk("rsth_buf",   dut.r_ld_buf, 0);
    @(negedge clk); reset = 0;
    tick();
    load(4'hF, 2'd0, 1'b0, 5'd21);
    bus.data_data_ok = 1; bus.data_rdata = 32'h0BAD_F00D;
    #3;
    chk("rec_wen",   32'(bus.rf_wen), 1);
    chk("rec_wdata", bus.rf_wdata, 32'h0BAD_F00D);

    // randomized run against the transaction-level model
    tick();
    m_have = 0;
    m_buf  = 0;
    rand_instr();
    for (int c = 0; c < 600; c++) begin
      need = bus.wb_data_req & bus.wb_load;
      bus.data_data_ok = (need && !m_have) ? 1'($urandom_range(0, 2) == 0) : 1'b0;
      bus.data_rdata   = $urandom;
      bus.ext_stall    = 1'($urandom_range(0, 2) == 0);
      #3;
      ready  = !need || bus.data_data_ok || m_have;
      commit = ready && !bus.ext_stall;
      src    = m_have ? m_buf : bus.data_rdata;
      chk("rnd_stall", 32'(bus.wb_stall_req), 32'(need && !ready));
      chk("rnd_wen",   32'(bus.rf_wen), 32'(commit && bus.wb_regwen));
      chk("rnd_fwd",   32'(bus.fwd_valid), 32'(ready && bus.wb_regwen));
      if (ready)
        chk("rnd_wdata", bus.rf_wdata, ref_wdata(src));
      tick();
      if (commit) begin
        m_have = 0;
        rand_instr();
      end else if (need && bus.data_data_ok && !m_have) begin
        m_have = 1;
        m_buf  = bus.data_rdata;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
